// File: rtl/adc_ad4003_ctrl_if.sv
// adc_ad4003_ctrl_if: acquisition control and status bundle for the AD4003 sequencer
interface adc_ad4003_ctrl_if;
    logic        acq_en;
    logic        adc_cnv;
    logic        sck_en;
    logic        reader_en_sync;
    logic        data_valid;
    logic        busy;
    logic        overrun;
    logic [31:0] sample_cnt;
    modport master (
        input  acq_en,
        output adc_cnv, sck_en, reader_en_sync, data_valid, busy, overrun, sample_cnt
    );
    modport slave (
        output acq_en,
        input  adc_cnv, sck_en, reader_en_sync, data_valid, busy, overrun, sample_cnt
    );
endinterface

// File: rtl/adc_ad4003_ctrl.sv
// adc_ad4003_ctrl: paces AD4003 conversions and sequences CNV, SCK forwarding and shift-register readout
module adc_ad4003_ctrl #(
    parameter int ADC_DATA_WIDTH  = 18,
    parameter int CNV_HIGH_CYCLES = 2,
    parameter int CONV_CYCLES     = 24,
    parameter int READ_LAT        = 4,
    parameter int SAMPLE_PERIOD   = 80,
    parameter int TCQ             = 1
) (
    input logic                adc_clk,
    input logic                rst,
    adc_ad4003_ctrl_if.master  bus
);
    localparam int TW = $clog2(CONV_CYCLES + ADC_DATA_WIDTH + READ_LAT + 2);
    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [TW-1:0] T_CNV   = TW'(CNV_HIGH_CYCLES);
    localparam logic [TW-1:0] T_CONV  = TW'(CONV_CYCLES);
    localparam logic [TW-1:0] T_READ  = TW'(CONV_CYCLES + ADC_DATA_WIDTH);
    localparam logic [TW-1:0] T_DRAIN = TW'(CONV_CYCLES + ADC_DATA_WIDTH + READ_LAT);
    localparam logic [PW-1:0] P_LAST  = PW'(SAMPLE_PERIOD - 1);

    if (CONV_CYCLES <= CNV_HIGH_CYCLES) begin : g_bad_conv
        $error("CONV_CYCLES must be greater than CNV_HIGH_CYCLES");
    end
    if (READ_LAT < 0) begin : g_bad_lat
        $error("READ_LAT must be at least 0");
    end
    if (CNV_HIGH_CYCLES < 1) begin : g_bad_cnv
        $error("CNV_HIGH_CYCLES must be at least 1");
    end
    if (TCQ < 0) begin : g_bad_tcq
        $error("TCQ must be non-negative");
    end

    typedef enum logic [2:0] {IDLE, CNV, WAIT, READ, DRAIN, DONE} state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  per_cnt;
    logic [TW-1:0]  t_cnt;
    logic           tick;

    assign tick = bus.acq_en && per_cnt == '0 && !rst;

    // period counter: held at 0 while disabled so re-enabling ticks immediately
    always_ff @(posedge adc_clk)
        if (rst || !bus.acq_en) per_cnt <= '0;
        else per_cnt <= per_cnt == P_LAST ? '0 : per_cnt + 1'b1;

    // state register plus frame-relative cycle count (t_cnt equals t from t=1 on)
    always_ff @(posedge adc_clk)
        if (rst) begin
            state <= IDLE;
            t_cnt <= '0;
        end else begin
            state <= state_nxt;
            t_cnt <= state == IDLE ? TW'(1) : t_cnt + 1'b1;
        end

    // next-state decode and frame-phase outputs
    always_comb begin
        state_nxt      = state;
        bus.adc_cnv    = 1'b0;
        bus.sck_en     = 1'b0;
        bus.data_valid = 1'b0;
        bus.busy       = tick || state != IDLE;
        case (state)
            IDLE:  if (tick) state_nxt = CNV;
            CNV: begin
                bus.adc_cnv = 1'b1;
                if (t_cnt == T_CNV) state_nxt = WAIT;
            end
            WAIT:  if (t_cnt == T_CONV) state_nxt = READ;
            READ: begin
                bus.sck_en = 1'b1;
                if (t_cnt == T_READ) state_nxt = READ_LAT == 0 ? DONE : DRAIN;
            end
            DRAIN: if (t_cnt == T_DRAIN) state_nxt = DONE;
            DONE: begin
                bus.data_valid = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    if (READ_LAT == 0) begin : g_no_lat
        assign bus.reader_en_sync = bus.sck_en;
    end else begin : g_lat
        logic [READ_LAT-1:0] dly;
        // delay line matching the SCK round trip and SDO output delay
        always_ff @(posedge adc_clk)
            dly <= rst ? '0 : (dly << 1) | READ_LAT'(bus.sck_en);
        assign bus.reader_en_sync = dly[READ_LAT-1];
    end

    // sticky overrun on a tick that finds a frame in flight; completed-frame counter
    always_ff @(posedge adc_clk)
        if (rst) begin
            bus.overrun    <= 1'b0;
            bus.sample_cnt <= '0;
        end else begin
            if (tick && state != IDLE) bus.overrun <= 1'b1;
            if (state == DONE) bus.sample_cnt <= bus.sample_cnt + 1'b1;
        end
endmodule

// File: tb/tb_adc_ad4003_ctrl.sv
// tb_adc_ad4003_ctrl: directed timing checks plus an ADC/shift-register scoreboard
module tb_adc_ad4003_ctrl;
    localparam int W    = 18;
    localparam int CNVH = 2;
    localparam int CONV = 24;
    localparam int RL   = 4;

    logic adc_clk = 1'b0;
    logic rst     = 1'b1;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   dv_cnt  = 0;
    int   dv0;

    logic [159:0] v_cnv, v_sck, v_ren, v_dv, v_bsy, v_ovr;

    adc_ad4003_ctrl_if b0();
    adc_ad4003_ctrl_if b1();
    adc_ad4003_ctrl_if b2();

    adc_ad4003_ctrl u0 (.adc_clk(adc_clk), .rst(rst), .bus(b0));
    adc_ad4003_ctrl #(.SAMPLE_PERIOD(40)) u1 (.adc_clk(adc_clk), .rst(rst), .bus(b1));
    adc_ad4003_ctrl #(.READ_LAT(0), .ADC_DATA_WIDTH(16)) u2 (.adc_clk(adc_clk), .rst(rst), .bus(b2));

    always #5 adc_clk = ~adc_clk;

    logic [W-1:0]  cur      = '0;
    logic [W-1:0]  sr       = '0;
    logic [W-1:0]  nxt_word = 18'h2A5C3;
    logic [W-1:0]  exp_w;
    logic [RL-1:0] line     = '0;
    logic          cnv_d    = 1'b0;
    int            idx      = 0;
    logic [W-1:0]  exp_q[$];

    // ADC model: latch a word on CNV rise, shift it out MSB-first on SCK, SDO returns RL clocks later
    always @(posedge adc_clk) begin
        cnv_d <= b0.adc_cnv;
        if (b0.adc_cnv && !cnv_d) begin
            cur      <= nxt_word;
            exp_q.push_back(nxt_word);
            nxt_word <= W'($urandom);
            idx      <= 0;
        end
        if (b0.sck_en) begin
            line <= {line[RL-2:0], cur[W-1-idx]};
            idx  <= idx + 1;
        end else line <= {line[RL-2:0], 1'b0};
        if (b0.reader_en_sync) sr <= {sr[W-2:0], line[RL-1]};
    end

    // scoreboard: each data_valid must present the oldest converted word
    always @(negedge adc_clk)
        if (b0.data_valid) begin
            dv_cnt++;
            n_cmp++;
            exp_w = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
            assert (sr === exp_w) else begin
                n_err++;
                $error("FAIL sb_data observed=%h expected=%h", sr, exp_w);
            end
        end

    function automatic logic [159:0] rng(input int a, input int b);
        logic [159:0] v = '0;
        for (int i = a; i <= b; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge adc_clk);
            #1;
        end
    endtask

    task automatic set_acq(input int dut, input logic v);
        if (dut == 0) b0.acq_en = v;
        else if (dut == 1) b1.acq_en = v;
        else b2.acq_en = v;
    endtask

    // record n cycles starting at the current tick cycle t=0
    task automatic rec(input int dut, input int n, input int drop_t, input int raise_t);
        {v_cnv, v_sck, v_ren, v_dv, v_bsy, v_ovr} = '0;
        for (int t = 0; t < n; t++) begin
            if (t > 0) cyc(1);
            if (t == drop_t) set_acq(dut, 1'b0);
            if (t == raise_t) set_acq(dut, 1'b1);
            @(negedge adc_clk);
            case (dut)
                0: {v_cnv[t], v_sck[t], v_ren[t], v_dv[t], v_bsy[t], v_ovr[t]} = {b0.adc_cnv, b0.sck_en, b0.reader_en_sync, b0.data_valid, b0.busy, b0.overrun};
                1: {v_cnv[t], v_sck[t], v_ren[t], v_dv[t], v_bsy[t], v_ovr[t]} = {b1.adc_cnv, b1.sck_en, b1.reader_en_sync, b1.data_valid, b1.busy, b1.overrun};
                default: {v_cnv[t], v_sck[t], v_ren[t], v_dv[t], v_bsy[t], v_ovr[t]} = {b2.adc_cnv, b2.sck_en, b2.reader_en_sync, b2.data_valid, b2.busy, b2.overrun};
            endcase
        end
    endtask

    initial begin
        b0.acq_en = 1'b0;
        b1.acq_en = 1'b0;
        b2.acq_en = 1'b0;
        cyc(4);
        @(negedge adc_clk);
        chk("reset_u0", 160'({b0.adc_cnv, b0.sck_en, b0.reader_en_sync, b0.data_valid, b0.busy, b0.overrun, b0.sample_cnt}), '0);
        chk("reset_u1", 160'({b1.adc_cnv, b1.sck_en, b1.reader_en_sync, b1.data_valid, b1.busy, b1.overrun, b1.sample_cnt}), '0);
        chk("reset_u2", 160'({b2.adc_cnv, b2.sck_en, b2.reader_en_sync, b2.data_valid, b2.busy, b2.overrun, b2.sample_cnt}), '0);
        cyc(1);
        rst = 1'b0;
        cyc(1);

        b0.acq_en = 1'b1;
        rec(0, 84, -1, -1);
        chk("frame_cnv", v_cnv, rng(1, CNVH) | rng(81, 80 + CNVH));
        chk("frame_sck", v_sck, rng(CONV + 1, CONV + W));
        chk("frame_ren", v_ren, rng(CONV + RL + 1, CONV + W + RL));
        chk("frame_dv", v_dv, rng(CONV + W + RL + 1, CONV + W + RL + 1));
        chk("frame_busy", v_bsy, rng(0, 47) | rng(80, 83));

        for (int i = 0; i < 400 * 80 && dv_cnt < 400; i++) @(posedge adc_clk);
        chk("dv_count_400", 160'(dv_cnt), 160'(400));
        @(negedge adc_clk);
        chk("sample_cnt_400", 160'(b0.sample_cnt), 160'(400));
        chk("overrun_default", 160'(b0.overrun), '0);
        cyc(1);
        b0.acq_en = 1'b0;
        cyc(40);

        b0.acq_en = 1'b1;
        cyc(30);
        rst = 1'b1;
        b0.acq_en = 1'b0;
        cyc(1);
        rst = 1'b0;
        @(negedge adc_clk);
        chk("midframe_rst", 160'({b0.adc_cnv, b0.sck_en, b0.reader_en_sync, b0.data_valid, b0.busy, b0.sample_cnt}), '0);
        dv0 = dv_cnt;
        exp_q.delete();
        cyc(100);
        chk("no_dv_after_rst", 160'(dv_cnt), 160'(dv0));

        b0.acq_en = 1'b1;
        rec(0, 104, 10, 100);
        chk("drop_cnv", v_cnv, rng(1, CNVH) | rng(101, 100 + CNVH));
        chk("drop_dv", v_dv, rng(47, 47));
        chk("drop_busy", v_bsy, rng(0, 47) | rng(100, 103));
        cyc(1);
        b0.acq_en = 1'b0;
        cyc(60);
        @(negedge adc_clk);
        chk("drop_sample_cnt", 160'(b0.sample_cnt), 160'(2));

        cyc(1);
        b1.acq_en = 1'b1;
        rec(1, 130, -1, -1);
        chk("ovr_cnv", v_cnv, rng(1, CNVH) | rng(81, 80 + CNVH));
        chk("ovr_flag", v_ovr, rng(41, 129));
        chk("ovr_dv", v_dv, rng(47, 47) | rng(127, 127));
        chk("ovr_sample_cnt", 160'(b1.sample_cnt), 160'(2));
        cyc(1);
        b1.acq_en = 1'b0;

        cyc(1);
        b2.acq_en = 1'b1;
        rec(2, 50, -1, -1);
        chk("lat0_sck", v_sck, rng(CONV + 1, CONV + 16));
        chk("lat0_ren", v_ren, rng(CONV + 1, CONV + 16));
        chk("lat0_dv", v_dv, rng(CONV + 17, CONV + 17));
        chk("lat0_busy", v_bsy, rng(0, CONV + 17));
        cyc(1);
        b2.acq_en = 1'b0;
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
